// File: rtl/rr_packet_mux_if.sv
// Stream bundle for rr_packet_mux: NUM request lanes in, one tagged packet stream out.
// master is the environment (requesters + sink), slave is the multiplexer.
interface rr_packet_mux_if #(
    parameter int NUM = 4,
    parameter int DW  = 8
);
    logic [NUM-1:0]    in_valid;
    logic [NUM*DW-1:0] in_data;
    logic [NUM-1:0]    in_last;
    logic [NUM-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [NUM-1:0]    out_src;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_src
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output out_src
    );
endinterface

// File: rtl/rr_packet_mux.sv
// Round-robin N:1 packet mux: grant held for a whole in_last-delimited packet,
// winning beat registered into a one-entry output stage.
module rr_packet_mux #(
    parameter int NUM = 4,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    rr_packet_mux_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [NUM-1:0] prio_q, prio_d;
    logic [NUM-1:0] lock_q, lock_d;

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic [NUM-1:0] out_src_q, out_src_d;

    logic [2*NUM-1:0] req_dbl;
    logic [2*NUM-1:0] base_dbl;
    logic [2*NUM-1:0] gnt_dbl;
    logic [NUM-1:0]   rr_gnt;
    logic [NUM-1:0]   gnt;
    logic [NUM-1:0]   gnt_rotl;
    logic [NUM-1:0]   in_ready;
    logic             slot_free;
    logic             in_xfer;
    logic             sel_last;
    logic [DW-1:0]    sel_data;

    // Subtracting the one-hot base from the doubled request isolates the first
    // requester at or above prio; the upper copy handles the wrap.
    assign req_dbl  = {bus.in_valid, bus.in_valid};
    assign base_dbl = {{NUM{1'b0}}, prio_q};
    assign gnt_dbl  = req_dbl & ~(req_dbl - base_dbl);
    assign rr_gnt   = gnt_dbl[NUM-1:0] | gnt_dbl[2*NUM-1:NUM];

    assign gnt       = (state_q == LOCKED) ? lock_q : rr_gnt;
    assign gnt_rotl  = {gnt[NUM-2:0], gnt[NUM-1]};
    assign slot_free = !out_valid_q || bus.out_ready;
    assign in_ready  = gnt & {NUM{slot_free}};
    assign in_xfer   = |(bus.in_valid & in_ready);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | bus.in_data[i*DW +: DW];
                sel_last = sel_last | bus.in_last[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        lock_d  = lock_q;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    if (sel_last) begin
                        prio_d = gnt_rotl;
                    end else begin
                        state_d = LOCKED;
                        lock_d  = gnt;
                    end
                end
            end
            LOCKED: begin
                // An idle owner keeps the lock; there is no pre-emption.
                if (in_xfer && sel_last) begin
                    state_d = IDLE;
                    prio_d  = gnt_rotl;
                    lock_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                lock_d  = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = gnt;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prio_q      <= {{(NUM-1){1'b0}}, 1'b1};
            lock_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;

endmodule
